step_shaper: RTL
================

// Module: step_shaper
// PURPOSE
//  Per-axis step/dir conditioner between the motion core step outputs and the driver pins.
//  Enforces dir-to-step setup time and minimum pulse high/low widths, buffers one pending step,
//  tracks signed absolute position, and rejects steps that would cross soft limits.
//  One instance per axis (x, y, z).
// PARAMETERS
//  DIR_SETUP  250  clk cycles dir_out must be stable before a step_out rising edge (>=1)
//  PULSE_W    250  clk cycles step_out is held high, and minimum low time after it (>=1)
//  POS_W      16   width of signed position and limit values
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      async active-low reset
//  enable     in   1      0: requests still buffer, but no new pulse starts (current one completes)
//  step_in    in   1      step request; rising edge = one step (synchronous to clk)
//  dir_in     in   1      direction sampled with step_in edge; 1 = +, 0 = -
//  zero_pos   in   1      1-cycle strobe: position <= 0
//  pos_min    in   POS_W  signed lower soft limit (inclusive)
//  pos_max    in   POS_W  signed upper soft limit (inclusive)
//  step_out   out  1      shaped step to driver
//  dir_out    out  1      direction to driver
//  position   out  POS_W  signed step count
//  busy       out  1      1 when state != IDLE or a step is pending
//  limit_hit  out  1      1-cycle pulse when a pending step is dropped by a soft limit
//  overrun    out  1      sticky; set when an edge arrives while pending buffer full
// BEHAVIOUR
//  Reset: step_out=0, dir_out=0, position=0, busy=0, limit_hit=0, overrun=0, pending empty, IDLE.
//  Edge detect: step_in registered; edge = step_in & ~step_in_q. Edge stores {dir_in} in pending.
//  Pending full + new edge: new edge discarded, overrun<=1 (cleared only by reset).
//  Edge in the cycle the pending slot is consumed: accepted (slot frees and refills), no overrun.
//  FSM IDLE -> SETUP | PULSE | IDLE (drop), SETUP -> PULSE, PULSE -> GAP, GAP -> IDLE.
//   IDLE: if pending & enable: limit check first (see CONFIGURATION); dropped -> pending cleared,
//         limit_hit=1 for one cycle, stay IDLE. Else if pend_dir != dir_out: dir_out<=pend_dir,
//         counter<=DIR_SETUP-1, ->SETUP. Else ->PULSE. Pending consumed on leaving IDLE.
//   SETUP: count down; at 0 ->PULSE.
//   PULSE: step_out=1 exactly PULSE_W cycles; position +/-1 on entry cycle (registered, visible
//          with step_out rising edge). Then ->GAP.
//   GAP: step_out=0 for PULSE_W cycles, then ->IDLE. Max step rate = 1/(2*PULSE_W+1) clk.
//  Latency: edge at cycle t, same dir, IDLE -> step_out high at t+2. Dir change adds DIR_SETUP.
//  position wraps two's-complement on overflow (no saturation); limits prevent this in practice.
//  zero_pos and position increment in same cycle: zero wins (position=0).
//  enable deasserted mid-SETUP/PULSE/GAP: sequence completes; next pulse waits in IDLE.
//  rst_n asserted mid-pulse: step_out drops asynchronously; pending lost.
// CONFIGURATION
//  STEP_SHAPER_LIMIT_EN defined: step with pend_dir=1 dropped if position>=pos_max;
//   pend_dir=0 dropped if position<=pos_min (signed compare). Drop does not change dir_out.
//  Not defined: pos_min/pos_max ignored, no step ever dropped, limit_hit tied 0. Ports unchanged.
// TESTING  (DIR_SETUP=4, PULSE_W=3, POS_W=16, LIMIT_EN defined unless noted)
//  1 edge dir=0 from reset -> step_out high t+2..t+4, position 0 -> -1, dir_out stays 0.
//  2 dir=1 edge after reset -> dir_out=1 at t+2, step_out rises t+6 (4 setup), position=+1.
//  3 three edges 1 cycle apart, same dir -> 2 pulses emitted (7-cycle spacing), overrun=1.
//  4 pos_max=2, 5 edges dir=1 spaced 10 cycles -> 2 pulses, position=2, limit_hit pulses x3.
//  5 zero_pos strobe on PULSE entry cycle of step 5 (+) -> position=0 afterwards.
//  6 LIMIT_EN undefined, pos_max=0, 3 edges dir=1 -> 3 pulses, position=3, limit_hit never 1.

Source files
------------

// File: rtl/step_shaper_if.sv
// step_shaper_if: bundles the per-axis step request inputs and the shaped driver-side outputs
// of step_shaper.
//   master : motion core / testbench side (drives requests, observes outputs)
//   slave  : step_shaper side
// Signals:
//   enable, step_in, dir_in, zero_pos   request/control inputs to the shaper
//   pos_min, pos_max                    signed soft limits (inclusive)
//   step_out, dir_out                   shaped driver pins
//   position                            signed step count
//   busy, limit_hit, overrun            status
interface step_shaper_if #(
   parameter int POS_W = 16
);
   logic                    enable;
   logic                    step_in;
   logic                    dir_in;
   logic                    zero_pos;
   logic signed [POS_W-1:0] pos_min;
   logic signed [POS_W-1:0] pos_max;
   logic                    step_out;
   logic                    dir_out;
   logic signed [POS_W-1:0] position;
   logic                    busy;
   logic                    limit_hit;
   logic                    overrun;

   modport master (
      output enable, step_in, dir_in, zero_pos, pos_min, pos_max,
      input  step_out, dir_out, position, busy, limit_hit, overrun
   );

   modport slave (
      input  enable, step_in, dir_in, zero_pos, pos_min, pos_max,
      output step_out, dir_out, position, busy, limit_hit, overrun
   );
endinterface

// File: rtl/step_shaper.sv
// step_shaper: per-axis step/dir conditioner between motion core and driver pins.
// Enforces dir-to-step setup time and minimum step high/low widths, buffers one pending
// step, tracks signed absolute position and (optionally) drops steps crossing soft limits.
// Optional feature macro: STEP_SHAPER_LIMIT_EN (soft-limit checking; otherwise pos_min/pos_max
// are ignored and limit_hit stays 0).
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   sif    step_shaper_if.slave (enable, step_in, dir_in, zero_pos, pos_min, pos_max in;
//          step_out, dir_out, position, busy, limit_hit, overrun out)
module step_shaper #(
   parameter int DIR_SETUP = 250,
   parameter int PULSE_W   = 250,
   parameter int POS_W     = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   step_shaper_if.slave  sif
);

   localparam int CMAX  = (DIR_SETUP > PULSE_W) ? DIR_SETUP : PULSE_W;
   localparam int CNT_W = $clog2(CMAX + 1);

   typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    step_in_q;
   logic                    pend_q;
   logic                    pend_dir_q;
   logic                    step_out_q;
   logic                    dir_out_q;
   logic signed [POS_W-1:0] position_q;
   logic                    limit_hit_q;
   logic                    overrun_q;

   logic step_edge_d;
   logic consume_d;
   logic drop_d;
   logic start_pulse_d;

   always_comb begin
      step_edge_d = sif.step_in & ~step_in_q;
      // The pending slot is taken (either issued or dropped) only from IDLE with enable high.
      consume_d   = (state_q == IDLE) & pend_q & sif.enable;
      drop_d      = 1'b0;
`ifdef STEP_SHAPER_LIMIT_EN
      if (consume_d) begin
         if (pend_dir_q) drop_d = (position_q >= sif.pos_max);
         else            drop_d = (position_q <= sif.pos_min);
      end
`endif
      start_pulse_d = (consume_d & ~drop_d & (pend_dir_q == dir_out_q)) |
                      ((state_q == SETUP) & (cnt_q == '0));
   end

`ifndef STEP_SHAPER_LIMIT_EN
   logic unused_limits;
   assign unused_limits = ^{sif.pos_min, sif.pos_max};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         step_in_q   <= 1'b0;
         pend_q      <= 1'b0;
         pend_dir_q  <= 1'b0;
         step_out_q  <= 1'b0;
         dir_out_q   <= 1'b0;
         position_q  <= '0;
         limit_hit_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         step_in_q   <= sif.step_in;
         limit_hit_q <= 1'b0;

         // Pending slot: a slot freed this cycle can be refilled by a same-cycle edge.
         if (consume_d) pend_q <= 1'b0;
         if (step_edge_d) begin
            if (pend_q && !consume_d) begin
               overrun_q <= 1'b1;
            end else begin
               pend_q     <= 1'b1;
               pend_dir_q <= sif.dir_in;
            end
         end

         case (state_q)
            IDLE: begin
               if (consume_d) begin
                  if (drop_d) begin
                     limit_hit_q <= 1'b1;
                  end else if (pend_dir_q != dir_out_q) begin
                     dir_out_q <= pend_dir_q;
                     cnt_q     <= CNT_W'(DIR_SETUP - 1);
                     state_q   <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            PULSE: begin
               if (cnt_q == '0) begin
                  step_out_q <= 1'b0;
                  cnt_q      <= CNT_W'(PULSE_W - 1);
                  state_q    <= GAP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == '0) state_q <= IDLE;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase

         // dir_out already holds the step direction when a pulse starts (pend_dir may have
         // been refilled by a newer request during SETUP).
         if (start_pulse_d) begin
            step_out_q <= 1'b1;
            cnt_q      <= CNT_W'(PULSE_W - 1);
            state_q    <= PULSE;
            position_q <= dir_out_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
         end

         if (sif.zero_pos) position_q <= '0;
      end
   end

   assign sif.step_out  = step_out_q;
   assign sif.dir_out   = dir_out_q;
   assign sif.position  = position_q;
   assign sif.busy      = (state_q != IDLE) | pend_q;
   assign sif.limit_hit = limit_hit_q;
   assign sif.overrun   = overrun_q;

endmodule
